fifo_push_pop_gen: RTL and testbench

//  Producer/consumer side of the push/pop counted-FIFO interface. Turns raw write/read

---
 rtl/fifo_push_pop_gen.sv | 117 +++++++++++
 tb/tb_fifo_push_pop_gen.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/fifo_push_pop_gen.sv
// Push/pop strobe generator for a counted FIFO: grants requests against a shadow
// occupancy count, runs a hysteresis watermark FSM and cross-checks the FIFO counter.
module fifo_push_pop_gen #(
  parameter int unsigned MAXCOUNT = 16,
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned HI_WM    = 12,
  parameter int unsigned LO_WM    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_req,
  input  logic             rd_req,
  input  logic [CNT_W-1:0] fifo_count,
  output logic             push,
  output logic             pop,
  output logic [CNT_W-1:0] shadow_count,
  output logic [1:0]       state,
  output logic             almost_full,
  output logic             wr_blocked,
  output logic             rd_blocked,
  output logic             sync_err
);

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_HIGH   = 2'd2,
    ST_FULL   = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAXCOUNT);
  localparam logic [CNT_W-1:0] HI_C  = CNT_W'(HI_WM);
  localparam logic [CNT_W-1:0] LO_C  = CNT_W'(LO_WM);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] shadow_q, shadow_d;
  logic [CNT_W-1:0] shadow_d1_q;
  logic             push_q, pop_q;
  logic             wr_blk_q, rd_blk_q;
  logic             af_q, af_d;
  logic             armed_q;
  logic             sync_err_q, sync_err_d;
  logic             can_push, can_pop;
  logic             push_grant, pop_grant;

  // Grants: a concurrent read frees the slot, so a full FIFO still accepts a write
  always_comb begin
    can_push   = (shadow_q < MAX_C);
    can_pop    = (shadow_q != '0);
    pop_grant  = rd_req & can_pop;
    push_grant = wr_req & (can_push | pop_grant);
    shadow_d   = shadow_q + CNT_W'(push_grant) - CNT_W'(pop_grant);
  end

  // Watermark FSM next state, driven by the post-update count
  always_comb begin
    state_d = state_q;
    af_d    = 1'b0;
    if (shadow_d == '0) begin
      state_d = ST_EMPTY;
    end else if (shadow_d == MAX_C) begin
      state_d = ST_FULL;
    end else begin
      unique case (state_q)
        ST_EMPTY, ST_ACTIVE: state_d = (shadow_d >= HI_C) ? ST_HIGH : ST_ACTIVE;
        ST_HIGH:             state_d = (shadow_d <= LO_C) ? ST_ACTIVE : ST_HIGH;
        ST_FULL:             state_d = (shadow_d > LO_C) ? ST_HIGH : ST_ACTIVE;
        default:             state_d = ST_EMPTY;
      endcase
    end
    af_d = (state_d == ST_HIGH) || (state_d == ST_FULL);
  end

  // Counter lags shadow by one edge; check is armed one edge after reset drops
  always_comb begin
    sync_err_d = sync_err_q;
    if (armed_q && (fifo_count != shadow_d1_q)) begin
      sync_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      shadow_q    <= '0;
      shadow_d1_q <= '0;
      push_q      <= 1'b0;
      pop_q       <= 1'b0;
      wr_blk_q    <= 1'b0;
      rd_blk_q    <= 1'b0;
      af_q        <= 1'b0;
      armed_q     <= 1'b0;
      sync_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      shadow_d1_q <= shadow_q;
      push_q      <= push_grant;
      pop_q       <= pop_grant;
      wr_blk_q    <= wr_req & ~push_grant;
      rd_blk_q    <= rd_req & ~pop_grant;
      af_q        <= af_d;
      armed_q     <= 1'b1;
      sync_err_q  <= sync_err_d;
    end
  end

  assign push         = push_q;
  assign pop          = pop_q;
  assign shadow_count = shadow_q;
  assign state        = state_q;
  assign almost_full  = af_q;
  assign wr_blocked   = wr_blk_q;
  assign rd_blocked   = rd_blk_q;
  assign sync_err     = sync_err_q;

endmodule

// File: tb/tb_fifo_push_pop_gen.sv
// Bench for fifo_push_pop_gen: models the FIFO counter and checks every cycle
// against an occupancy/watermark reference model, directed phases then random.
module tb_fifo_push_pop_gen;

  localparam int MAXC = 16;
  localparam int HI   = 12;
  localparam int LO   = 4;

  logic        clk = 1'b0;
  logic        rst, wr_req, rd_req;
  logic [31:0] fifo_count;
  logic        push, pop, almost_full, wr_blocked, rd_blocked, sync_err;
  logic [31:0] shadow_count;
  logic [1:0]  state;

  int cnt = 0;
  int inj = 0;
  int n_assert = 0;
  int n_fail   = 0;

  // reference model state
  int  m_s = 0, m_sd1 = 0, m_st = 0, m_since = 0;
  bit  m_push, m_pop, m_wb, m_rb, m_err;
  int  n_push, n_pop;

  always #5 clk = ~clk;

  fifo_push_pop_gen dut (
    .clk(clk), .rst(rst), .wr_req(wr_req), .rd_req(rd_req),
    .fifo_count(fifo_count), .push(push), .pop(pop),
    .shadow_count(shadow_count), .state(state), .almost_full(almost_full),
    .wr_blocked(wr_blocked), .rd_blocked(rd_blocked), .sync_err(sync_err)
  );

  // FIFO occupancy counter consuming the strobes one edge after issue
  always @(posedge clk) begin
    if (rst) cnt <= 0;
    else     cnt <= cnt + int'(push) - int'(pop);
  end
  assign fifo_count = 32'(cnt + inj);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input bit w, input bit r, input bit rs, input int fault);
    int fc;
    bit pg, pp;
    wr_req = w; rd_req = r; rst = rs; inj = fault;
    fc = cnt + fault;
    @(posedge clk); #1;
    if (rs) begin
      m_s = 0; m_sd1 = 0; m_st = 0; m_since = 0;
      m_push = 0; m_pop = 0; m_wb = 0; m_rb = 0; m_err = 0;
    end else begin
      if (m_since < 2) m_since++;
      if (m_since >= 2 && fc != m_sd1) m_err = 1;
      m_sd1 = m_s;
      if (w && r)      begin pg = 1; pp = (m_s > 0); end
      else if (w)      begin pg = (m_s < MAXC); pp = 0; end
      else if (r)      begin pg = 0; pp = (m_s > 0); end
      else             begin pg = 0; pp = 0; end
      m_s = m_s + int'(pg) - int'(pp);
      if (m_s == 0)         m_st = 0;
      else if (m_s == MAXC) m_st = 3;
      else if (m_st == 2)   m_st = (m_s <= LO) ? 1 : 2;
      else if (m_st == 3)   m_st = (m_s > LO) ? 2 : 1;
      else                  m_st = (m_s >= HI) ? 2 : 1;
      m_push = pg; m_pop = pp; m_wb = w & !pg; m_rb = r & !pp;
    end
    inj = 0;
    n_push += int'(push); n_pop += int'(pop);
    chk("push", 32'(push), 32'(m_push));
    chk("pop", 32'(pop), 32'(m_pop));
    chk("shadow_count", shadow_count, 32'(m_s));
    chk("state", 32'(state), 32'(m_st));
    chk("almost_full", 32'(almost_full), 32'(m_st >= 2));
    chk("wr_blocked", 32'(wr_blocked), 32'(m_wb));
    chk("rd_blocked", 32'(rd_blocked), 32'(m_rb));
    chk("sync_err", 32'(sync_err), 32'(m_err));
    chk("fifomax", 32'(cnt <= MAXC), 32'd1);
  endtask

  initial begin
    wr_req = 0; rd_req = 0; rst = 1;
    // reset with a pending write
    step(1, 0, 1, 0);
    step(1, 0, 1, 0);
    chk("reset_push", 32'(push), 32'd0);
    chk("reset_state", 32'(state), 32'd0);

    // fill
    n_push = 0;
    for (int i = 0; i < 20; i++) step(1, 0, 0, 0);
    chk("fill_pushes", 32'(n_push), 32'd16);
    chk("fill_state", 32'(state), 32'd3);
    chk("fill_blocked", 32'(wr_blocked), 32'd1);

    // drain through hysteresis
    n_pop = 0;
    for (int i = 0; i < 11; i++) step(0, 1, 0, 0);
    chk("drain_at5_state", 32'(state), 32'd2);
    step(0, 1, 0, 0);
    chk("drain_at4_state", 32'(state), 32'd1);
    for (int i = 0; i < 6; i++) step(0, 1, 0, 0);
    chk("drain_pops", 32'(n_pop), 32'd16);
    chk("drain_empty", 32'(state), 32'd0);
    chk("drain_blocked", 32'(rd_blocked), 32'd1);

    // simultaneous at empty and at full
    step(1, 1, 0, 0);
    chk("both_empty_s", shadow_count, 32'd1);
    for (int i = 0; i < 15; i++) step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    chk("both_full_push", 32'(push), 32'd1);
    chk("both_full_pop", 32'(pop), 32'd1);
    chk("both_full_s", shadow_count, 32'd16);

    // sync error injection at s=5
    for (int i = 0; i < 11; i++) step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    chk("sync_err_set", 32'(sync_err), 32'd1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
    chk("sync_err_sticky", 32'(sync_err), 32'd1);

    // mid-op reset at s=9
    step(0, 0, 1, 0);
    for (int i = 0; i < 9; i++) step(1, 0, 0, 0);
    step(1, 1, 1, 0);
    chk("midrst_s", shadow_count, 32'd0);
    step(1, 1, 0, 0);
    chk("midrst_first_push", 32'(push), 32'd1);
    for (int i = 0; i < 4; i++) step(1, 1, 0, 0);
    chk("midrst_no_err", 32'(sync_err), 32'd0);

    // random traffic with occasional reset
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 63) == 0), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
